// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   // Width of the optional statistics counters
   localparam int unsigned STAT_W = 16;

   // Width of the access-cycle and streak counters (both limited to 1..15)
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MaxV)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM (CPU port 0, DMA port 1).
// CPU has fixed priority; a streak limiter lets a waiting DMA in after
// MAX_CPU_STREAK consecutive CPU grants.
// Optional statistics counters/ports: define DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ACC_CYCLES     = 1,
   parameter int unsigned MAX_CPU_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_cpu_grants,
   output logic [STAT_W-1:0] stat_dma_grants,
   output logic [STAT_W-1:0] stat_conflicts
`endif
);

   localparam logic [CNT_W-1:0] AccLast   = CNT_W'(ACC_CYCLES - 1);
   localparam logic [CNT_W-1:0] StreakMax = CNT_W'(MAX_CPU_STREAK);

   state_e              state_q;
   owner_e              owner_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    cyc_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic                cpu_ack_q;
   logic                dma_ack_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   dma_rdata_q;

   logic                grant_cpu;
   logic                grant_dma;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                streak_inc;
   logic                streak_clr;
   logic [CNT_W-1:0]    streak;

   // IDLE arbitration: CPU first unless a waiting DMA has hit the streak limit
   always_comb begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      if (state_q == IDLE) begin
         if (cpu_req && !(dma_req && (streak == StreakMax))) begin
            grant_cpu = 1'b1;
         end else if (dma_req) begin
            grant_dma = 1'b1;
         end
      end
   end

   // Request fields of the master being granted
   always_comb begin
      sel_we    = grant_dma ? dma_we    : cpu_we;
      sel_addr  = grant_dma ? dma_addr  : cpu_addr;
      sel_wdata = grant_dma ? dma_wdata : cpu_wdata;
   end

   assign streak_inc = grant_cpu & dma_req;
   assign streak_clr = grant_dma | ((state_q == IDLE) & ~dma_req);

   arb_sat_counter #(
      .WIDTH (CNT_W),
      .MAX   (MAX_CPU_STREAK)
   ) u_streak (
      .clk_i (clk),
      .rst_i (reset),
      .inc_i (streak_inc),
      .clr_i (streak_clr),
      .cnt_o (streak)
   );

   // Access sequencer: latch on grant, hold strobes ACC_CYCLES, ack in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cyc_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_cpu || grant_dma) begin
                  owner_q     <= grant_dma ? OWN_DMA : OWN_CPU;
                  we_q        <= sel_we;
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  cyc_q       <= AccLast;
                  mem_read_q  <= ~sel_we;
                  mem_write_q <= sel_we;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cyc_q == '0) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (!we_q) begin
                     if (owner_q == OWN_CPU) begin
                        cpu_rdata_q <= mem_rdata;
                     end else begin
                        dma_rdata_q <= mem_rdata;
                     end
                  end
                  cpu_ack_q <= (owner_q == OWN_CPU);
                  dma_ack_q <= (owner_q == OWN_DMA);
                  state_q   <= DONE;
               end else begin
                  cyc_q <= cyc_q - CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;

`ifdef DMEM_ARB_STATS_EN
   logic conflict;

   assign conflict = (state_q == IDLE) & cpu_req & dma_req;

   arb_sat_counter #(
      .WIDTH (STAT_W),
      .MAX   ((1 << STAT_W) - 1)
   ) u_stat_cpu (
      .clk_i (clk),
      .rst_i (reset),
      .inc_i (grant_cpu),
      .clr_i (1'b0),
      .cnt_o (stat_cpu_grants)
   );

   arb_sat_counter #(
      .WIDTH (STAT_W),
      .MAX   ((1 << STAT_W) - 1)
   ) u_stat_dma (
      .clk_i (clk),
      .rst_i (reset),
      .inc_i (grant_dma),
      .clr_i (1'b0),
      .cnt_o (stat_dma_grants)
   );

   arb_sat_counter #(
      .WIDTH (STAT_W),
      .MAX   ((1 << STAT_W) - 1)
   ) u_stat_conf (
      .clk_i (clk),
      .rst_i (reset),
      .inc_i (conflict),
      .clr_i (1'b0),
      .cnt_o (stat_conflicts)
   );
`else
   // Statistics disabled: no counters, no extra ports
`endif

endmodule
